// File: rtl/key_conditioner_pkg.sv
// Shared types and elaboration helpers for the key conditioner.
package key_conditioner_pkg;

  localparam int unsigned KC_STATE_W = 3;

  typedef struct packed {
    logic btn;
    logic lng;
    logic rpt;
    logic rel;
  } kc_pulse_t;

  function automatic int unsigned kc_clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((33'd1 << i) < {1'b0, v}) r = i + 1;
    end
    return r;
  endfunction

  function automatic int unsigned kc_max3(input int unsigned a, input int unsigned b,
                                          input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/key_conditioner_sync2.sv
// Two-flop synchronizer for asynchronous level inputs; clears to 0 on reset.
module sync2 #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q, meta_d;
  logic [WIDTH-1:0] sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/key_conditioner.sv
// Button debouncer with press/long-press/auto-repeat/release pulse generation.
module key_conditioner
  import key_conditioner_pkg::*;
#(
  parameter int unsigned DEB_CMAX = 10,
  parameter int unsigned LNG_CMAX = 50000000,
  parameter int unsigned RPT_CMAX = 10000000
) (
  input  logic clk,
  input  logic rst,
  input  logic a_btn,
  input  logic lock,
  output logic tr_btn,
  output logic tr_long,
  output logic tr_rpt,
  output logic tr_rel,
  output logic held
);

  localparam int unsigned CNT_W = kc_clog2(kc_max3(DEB_CMAX, LNG_CMAX, RPT_CMAX)) + 1;

  localparam logic [KC_STATE_W-1:0] S_IDLE    = 3'd0;
  localparam logic [KC_STATE_W-1:0] S_DEB_DN  = 3'd1;
  localparam logic [KC_STATE_W-1:0] S_PRESSED = 3'd2;
  localparam logic [KC_STATE_W-1:0] S_LONG    = 3'd3;
  localparam logic [KC_STATE_W-1:0] S_DEB_UP  = 3'd4;

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CMAX - 1);
  localparam logic [CNT_W-1:0] LNG_LAST = CNT_W'(LNG_CMAX - 1);
  localparam logic [CNT_W-1:0] RPT_LAST = CNT_W'(RPT_CMAX - 1);

  logic                  s_btn;
  logic [KC_STATE_W-1:0] state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  kc_pulse_t             pulse_q, pulse_d;
  logic                  held_q, held_d;

  sync2 #(.WIDTH(1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (a_btn),
    .q   (s_btn)
  );

  // Next-state, shared counter and pulse decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    pulse_d = '0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (s_btn && !lock) state_d = S_DEB_DN;
      end
      S_DEB_DN: begin
        if (!s_btn) begin
          state_d = S_IDLE;
        end else if (cnt_q == DEB_LAST) begin
          state_d     = S_PRESSED;
          pulse_d.btn = 1'b1;
        end
      end
      S_PRESSED: begin
        if (!s_btn) begin
          state_d = S_DEB_UP;
        end else if (cnt_q == LNG_LAST) begin
          state_d     = S_LONG;
          pulse_d.lng = 1'b1;
        end
      end
      S_LONG: begin
        if (!s_btn) begin
          state_d = S_DEB_UP;
        end else if (cnt_q == RPT_LAST) begin
          cnt_d       = '0;
          pulse_d.rpt = 1'b1;
        end
      end
      S_DEB_UP: begin
        if (s_btn) begin
          cnt_d = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d     = S_IDLE;
          pulse_d.rel = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (state_d != state_q) cnt_d = '0;
    if (lock) pulse_d = '0;
    held_d = (state_d == S_PRESSED) || (state_d == S_LONG);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      pulse_q <= '0;
      held_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
      held_q  <= held_d;
    end
  end

  assign tr_btn  = pulse_q.btn;
  assign tr_long = pulse_q.lng;
  assign tr_rpt  = pulse_q.rpt;
  assign tr_rel  = pulse_q.rel;
  assign held    = held_q;

endmodule

// File: doc/key_conditioner.md
KEY_CONDITIONER -- requirements
Module: key_conditioner

Interface
REQ-001 Parameter DEB_CMAX, default 10, debounce length in clk cycles (>=1).
REQ-002 Parameter LNG_CMAX, default 50000000, held cycles after press before long-press (>=1).
REQ-003 Parameter RPT_CMAX, default 10000000, auto-repeat period in clk cycles while long-pressed (>=1).
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 a_btn  input  1  raw asynchronous, bouncy button level; 1 = pressed.
REQ-007 lock  input  1  synchronous; 1 = suppress new presses and all output pulses.
REQ-008 tr_btn  output  1  one-cycle pulse on debounced press; drives a buzzer trigger input.
REQ-009 tr_long  output  1  one-cycle pulse when the press reaches long-press.
REQ-010 tr_rpt  output  1  one-cycle pulse every RPT_CMAX cycles during long-press.
REQ-011 tr_rel  output  1  one-cycle pulse on debounced release.
REQ-012 held  output  1  level; 1 while state is PRESSED or LONG.

Function
REQ-013 a_btn SHALL pass a two-flop synchronizer; the second flop (s_btn) is the only FSM input derived from a_btn.
REQ-014 FSM states: IDLE, DEB_DN, PRESSED, LONG, DEB_UP; one shared counter cnt, width clog2(max(DEB_CMAX,LNG_CMAX,RPT_CMAX))+1, cleared on every state change.
REQ-015 IDLE: s_btn=1 and lock=0 -> DEB_DN; otherwise stay (lock=1 blocks new presses).
REQ-016 DEB_DN: s_btn=0 -> IDLE, no pulse; s_btn=1 and cnt=DEB_CMAX-1 -> PRESSED; else cnt+1.
REQ-017 PRESSED: s_btn=0 -> DEB_UP; cnt=LNG_CMAX-1 -> LONG; else cnt+1.
REQ-018 LONG: s_btn=0 -> DEB_UP; cnt=RPT_CMAX-1 -> stay, cnt=0, tr_rpt pulse; else cnt+1.
REQ-019 DEB_UP: s_btn=1 -> stay, cnt=0; s_btn=0 and cnt=DEB_CMAX-1 -> IDLE; else cnt+1; no re-press until IDLE.
REQ-020 All tr_* outputs SHALL be registered, asserted in the cycle immediately following the causing edge: tr_btn on DEB_DN->PRESSED, tr_long on PRESSED->LONG, tr_rel on DEB_UP->IDLE.
REQ-021 Latency: counting the first edge sampling a_btn=1 as edge 1, tr_btn SHALL rise at edge DEB_CMAX+3.
REQ-022 lock=1 in any non-IDLE state SHALL force all tr_* to 0 that cycle while the FSM continues tracking; held unaffected by lock.
REQ-023 Pulses SHALL never exceed one cycle; at most one of tr_* high in any cycle.
REQ-024 Single bounce glitch of any length < DEB_CMAX cycles SHALL produce no pulse.

Reset
REQ-025 rst=1 at an edge SHALL force state IDLE, cnt=0, synchronizer flops=0, all outputs 0, including mid-press.
REQ-026 After reset release with a_btn held high, a full press sequence (DEB_CMAX debounce, then tr_btn) SHALL occur.

Structure
REQ-027 State encodings SHALL be module-local localparams; the counter-width clog2 helper SHALL live in the shared common header.
REQ-028 The synchronizer SHALL be a sub-module named sync2 (width parameter, reset to 0).

Verification (DEB_CMAX=4, LNG_CMAX=20, RPT_CMAX=5)
REQ-029 Clean press of 10 cycles -> tr_btn at edge 7, held high, tr_rel once DEB_CMAX cycles after s_btn falls, no tr_long.
REQ-030 Bounce pattern 1,0,1,1,0 then steady 1 -> exactly one tr_btn, 4 cycles after steady-1 reaches s_btn +1.
REQ-031 Hold 60 cycles -> tr_btn, tr_long 20 cycles later, tr_rpt every 5 cycles thereafter, one tr_rel after release.
REQ-032 lock=1 throughout while pressing -> no tr_* pulses, held stays 0; lock=1 only during LONG -> tr_rpt suppressed, resumes when lock=0.
REQ-033 rst asserted in LONG for 1 cycle with a_btn still 1 -> outputs 0 next cycle, new tr_btn 7 edges after reset release.
REQ-034 Release glitch of 2 cycles during DEB_UP -> single tr_rel, no second tr_btn.
